pmem_responder: RTL and testbench

- Memory-side responder for the NPC load/store path. It accepts one request at a time over a valid/ready channel and waits a programmable number of cycles.
- It then performs the physical-memory access through the DPI hooks npc_pmem_read/npc_pmem_write and returns a response over a second valid/ready channel.
- It builds byte lanes, aligns addresses and detects misalignment. Sign/zero extension stays with the requester.

---
 rtl/pmem_responder_pkg.sv | 72 +++++++
 rtl/pmem_lane_align.sv | 40 ++++
 rtl/pmem_responder.sv | 161 ++++++++++++++++
 tb/tb_pmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared state/size encodings, request payload type and the npc_pmem_* physical-memory hooks.
// Hooks are behavioural SV models: a sparse word memory plus call counters and a last-write log.
`ifndef PMEM_RESPONDER_DEFINES
`define PMEM_RESPONDER_DEFINES
`define PMEM_IDLE        2'd0
`define PMEM_BUSY        2'd1
`define PMEM_RESP        2'd2
`define DATASIZE_BYTE    2'b00
`define DATASIZE_HALWORD 2'b01
`define DATASIZE_WORD    2'b10
`endif

package pmem_responder_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANE_N  = 4;
  localparam int unsigned WMASK_W = 8;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = `PMEM_IDLE,
    ST_BUSY = `PMEM_BUSY,
    ST_RESP = `PMEM_RESP
  } pmem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } pmem_req_t;

  // Word-addressed backing store; absent words read as zero.
  logic [DATA_W-1:0]  pmem_mem [logic [ADDR_W-1:0]];
  int unsigned        pmem_rd_cnt;
  int unsigned        pmem_wr_cnt;
  logic [ADDR_W-1:0]  pmem_last_waddr;
  logic [DATA_W-1:0]  pmem_last_wdata;
  logic [WMASK_W-1:0] pmem_last_wmask;

  function automatic logic [DATA_W-1:0] npc_pmem_read(input logic [ADDR_W-1:0] addr);
    pmem_rd_cnt++;
    return pmem_mem.exists(addr) ? pmem_mem[addr] : 32'h0;
  endfunction

  function automatic void npc_pmem_write(input logic [ADDR_W-1:0]  addr,
                                         input logic [DATA_W-1:0]  data,
                                         input logic [WMASK_W-1:0] mask);
    logic [DATA_W-1:0] word;
    word = pmem_mem.exists(addr) ? pmem_mem[addr] : 32'h0;
    for (int i = 0; i < LANE_N; i++) begin
      if (mask[i]) word[8*i +: 8] = data[8*i +: 8];
    end
    pmem_mem[addr]  = word;
    pmem_wr_cnt++;
    pmem_last_waddr = addr;
    pmem_last_wdata = data;
    pmem_last_wmask = mask;
  endfunction

  function automatic void pmem_poke(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    pmem_mem[addr] = data;
  endfunction

  function automatic logic [ADDR_W+DATA_W+WMASK_W-1:0] pmem_last_write();
    return {pmem_last_waddr, pmem_last_wdata, pmem_last_wmask};
  endfunction

endpackage

// File: rtl/pmem_lane_align.sv
// Byte-lane steering: write lane mask/data shift, read shift/size mask, misalignment flag.
module pmem_lane_align
  import pmem_responder_pkg::*;
(
  input  logic [1:0]         i_offset,
  input  logic [SIZE_W-1:0]  i_size,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic [LANE_N-1:0]  o_wlane_c,
  output logic [DATA_W-1:0]  o_wdata_c,
  output logic [SHAMT_W-1:0] o_rshamt_c,
  output logic [DATA_W-1:0]  o_rmask_c,
  output logic               o_misalign_c
);

  logic [LANE_N-1:0] w_base_lane;

  // Size code 11 falls into the word branch.
  always_comb begin
    w_base_lane  = 4'b1111;
    o_rmask_c    = 32'hFFFF_FFFF;
    o_misalign_c = 1'b0;
    case (i_size)
      `DATASIZE_BYTE: begin
        w_base_lane = 4'b0001;
        o_rmask_c   = 32'h0000_00FF;
      end
      `DATASIZE_HALWORD: begin
        w_base_lane  = 4'b0011;
        o_rmask_c    = 32'h0000_FFFF;
        o_misalign_c = i_offset[0];
      end
      default: o_misalign_c = (i_offset != 2'b00);
    endcase
  end

  assign o_rshamt_c = {i_offset, 3'b000};
  assign o_wlane_c  = w_base_lane << i_offset;
  assign o_wdata_c  = i_wdata << o_rshamt_c;

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder: one request at a time, programmable latency, lane-aligned pmem access.
// Optional macro PMEM_RAND_DELAY_EN: LFSR-driven per-request latency in 1..LATENCY.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
    $error("pmem_responder: LATENCY must be in 1..15");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("pmem_responder: LFSR_SEED must be non-zero");
  end

  pmem_state_e        r_state;
  pmem_state_e        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_load;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  pmem_req_t          r_req;
  logic               w_accept;
  logic               w_access;
  logic               w_rsp_done;

  logic [ADDR_W-1:0]  w_aligned;
  logic [LANE_N-1:0]  w_wlane;
  logic [DATA_W-1:0]  w_wdata_sh;
  logic [SHAMT_W-1:0] w_rshamt;
  logic [DATA_W-1:0]  w_rmask;
  logic               w_misalign;

`ifdef PMEM_RAND_DELAY_EN
  logic [7:0] r_lfsr;

  // Galois LFSR, taps 8,6,5,4, free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  end

  assign w_cnt_load = r_lfsr[3:0] % CNT_W'(LATENCY);
`else
  assign w_cnt_load = CNT_W'(LATENCY - 1);
`endif

  pmem_lane_align u_lane_align (
    .i_offset     (r_req.addr[1:0]),
    .i_size       (r_req.size),
    .i_wdata      (r_req.wdata),
    .o_wlane_c    (w_wlane),
    .o_wdata_c    (w_wdata_sh),
    .o_rshamt_c   (w_rshamt),
    .o_rmask_c    (w_rmask),
    .o_misalign_c (w_misalign)
  );

  assign w_aligned = {r_req.addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = w_cnt_load;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // Request capture and the single memory access; reset drops anything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.addr  <= req_addr;
        r_req.wen   <= req_wen;
        r_req.size  <= req_size;
        r_req.wdata <= req_wdata;
      end
      if (w_access) begin
        if (w_misalign) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else if (r_req.wen) begin
          npc_pmem_write(w_aligned, w_wdata_sh, {4'b0000, w_wlane});
          r_rdata <= '0;
          r_err   <= 1'b0;
        end else begin
          r_rdata <= (npc_pmem_read(w_aligned) >> w_rshamt) & w_rmask;
          r_err   <= 1'b0;
        end
      end else if (w_rsp_done) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: directed requests push expected responses, a monitor pops them.
module tb_pmem_responder;
  import pmem_responder_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          n_cmp;
  int          n_err;
  logic [32:0] exp_q[$];
  logic [32:0] m_exp;

  pmem_responder #(.LATENCY(LAT), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        m_exp = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, m_exp[31:0]);
        check("rsp_err", 32'(rsp_err), 32'(m_exp[32]));
      end
    end
  end

  // Drive a request, return #1 after its acceptance edge with inputs scrambled and valid still high.
  task automatic issue(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                       input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wen   = wen;
    req_size  = size;
    req_wdata = wdata;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_addr  = ~addr;
    req_wen   = ~wen;
    req_size  = ~size;
    req_wdata = ~wdata;
    check("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic run_req(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int hold);
    int lat;
    exp_q.push_back({exp_err, exp_rdata});
    rsp_ready = (hold == 0);
    issue(addr, wen, size, wdata);
    wait_rsp(lat);
    req_valid = 1'b0;
`ifdef PMEM_RAND_DELAY_EN
    check("rsp_latency_range", 32'(lat >= 1 && lat <= int'(LAT)), 32'd1);
`else
    check("rsp_latency", 32'(lat), LAT);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, exp_rdata);
      check("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_last_write(input string name, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [7:0] mask);
    logic [71:0] lw;
    lw = pmem_last_write();
    check({name, "_addr"}, lw[71:40], addr);
    check({name, "_data"}, lw[39:8], data);
    check({name, "_mask"}, 32'(lw[7:0]), 32'(mask));
  endtask

  initial begin
    int unsigned rd0;
    int unsigned wr0;
    int          lat;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wen   = 1'b0;
    req_size  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    pmem_poke(32'h8000_0000, 32'hDEAD_BEEF);
    pmem_poke(32'h8000_0004, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word read, one memory read call.
    rd0 = pmem_rd_cnt;
    run_req(32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    check("word_read_calls", pmem_rd_cnt - rd0, 32'd1);

    // Byte write into lane 3, then read back.
    rd0 = pmem_rd_cnt;
    wr0 = pmem_wr_cnt;
    run_req(32'h8000_0003, 1'b1, 2'b00, 32'h0000_00AB, 32'h0, 1'b0, 0);
    check("byte_write_calls", pmem_wr_cnt - wr0, 32'd1);
    check("byte_write_no_read", pmem_rd_cnt - rd0, 32'd0);
    check_last_write("byte_write", 32'h8000_0000, 32'hAB00_0000, 8'h08);
    run_req(32'h8000_0003, 1'b0, 2'b00, 32'h0, 32'h0000_00AB, 1'b0, 0);
    run_req(32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'hABAD_BEEF, 1'b0, 0);
    run_req(32'h8000_0001, 1'b0, 2'b00, 32'h0, 32'h0000_00BE, 1'b0, 0);

    // Halfword lanes.
    run_req(32'h8000_0006, 1'b0, 2'b01, 32'h0, 32'h0000_1234, 1'b0, 0);
    run_req(32'h8000_0004, 1'b0, 2'b01, 32'h0, 32'h0000_5678, 1'b0, 0);
    run_req(32'h8000_0005, 1'b0, 2'b00, 32'h0, 32'h0000_0056, 1'b0, 0);
    run_req(32'h8000_0006, 1'b1, 2'b01, 32'h0000_CAFE, 32'h0, 1'b0, 0);
    check_last_write("half_write", 32'h8000_0004, 32'hCAFE_0000, 8'h0C);
    run_req(32'h8000_0004, 1'b0, 2'b10, 32'h0, 32'hCAFE_5678, 1'b0, 0);
    run_req(32'h8000_0004, 1'b0, 2'b11, 32'h0, 32'hCAFE_5678, 1'b0, 0);

    // Misaligned accesses: error, no memory call.
    rd0 = pmem_rd_cnt;
    wr0 = pmem_wr_cnt;
    run_req(32'h8000_0001, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    run_req(32'h8000_0003, 1'b0, 2'b01, 32'h0, 32'h0, 1'b1, 0);
    run_req(32'h8000_0002, 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 0);
    check("misalign_no_write", pmem_wr_cnt - wr0, 32'd0);
    check("misalign_no_read", pmem_rd_cnt - rd0, 32'd0);
    run_req(32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'hABAD_BEEF, 1'b0, 0);

    // Backpressure for 5 cycles.
    run_req(32'h8000_0004, 1'b0, 2'b10, 32'h0, 32'hCAFE_5678, 1'b0, 5);

    // Reset while BUSY: the write must never reach memory.
    wr0 = pmem_wr_cnt;
    issue(32'h8000_0010, 1'b1, 2'b10, 32'h55AA_55AA);
`ifndef PMEM_RAND_DELAY_EN
    @(posedge clk);
    #1;
`endif
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_busy_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_busy_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy_no_write", pmem_wr_cnt - wr0, 32'd0);
    run_req(32'h8000_0010, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 0);

    // Reset while RESP: the response is discarded.
    rsp_ready = 1'b0;
    issue(32'h8000_0000, 1'b0, 2'b10, 32'h0);
    wait_rsp(lat);
    req_valid = 1'b0;
    check("rst_resp_reached", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_resp_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    run_req(32'h8000_0004, 1'b0, 2'b01, 32'h0, 32'h0000_5678, 1'b0, 0);

    // Repeated reads; exercises the latency range when random delay is built in.
    for (int i = 0; i < 100; i++) begin
      run_req(32'h8000_0004, 1'b0, 2'b10, 32'h0, 32'hCAFE_5678, 1'b0, 0);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
